// File: rtl/uart_pkg.sv
// uart_pkg: shared constants and FSM state encodings for the UART host
// bridge (uart_host and uart_host_fifo).
//   DATA_W     - byte width moved between the CPU side and the UART core
//   tx_state_t - transmit sequencer states
//   rx_state_t - receive sequencer states
package uart_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_LOAD = 2'd1,
        T_BUSY = 2'd2,
        T_WAIT = 2'd3
    } tx_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_ACK  = 1'b1
    } rx_state_t;

endpackage

// File: rtl/uart_host_fifo.sv
// uart_host_fifo: first-word fall-through FIFO used for both the TX and RX
// queues of uart_host. DEPTH must be a power of two (2..64) so the pointers
// wrap naturally.
// Ports:
//   uart_clk, reset  clock / asynchronous active-high reset
//   push, wdata      write request and data (accepted when not full, or when
//                    a pop happens in the same cycle)
//   pop              read request (ignored when empty)
//   rdata            head of queue; when empty, the last byte popped (0 after reset)
//   count            occupancy, log2(DEPTH)+1 bits
//   full, empty      decoded from count
module uart_host_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                      uart_clk,
    input  logic                      reset,
    input  logic                      push,
    input  logic [DATA_W-1:0]         wdata,
    input  logic                      pop,
    output logic [DATA_W-1:0]         rdata,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [DATA_W-1:0] last_q;
    logic              push_ok;
    logic              pop_ok;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok = push && (!full || pop_ok);
    assign rdata   = empty ? last_q : mem[rd_ptr];

    always_ff @(posedge uart_clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
                last_q <= mem[rd_ptr];
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only, so it is not reset.
    always_ff @(posedge uart_clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/uart_host.sv
// uart_host: CPU-side bridge to a byte-oriented UART core. Bytes written by
// the CPU are queued and handed to the core one frame at a time; bytes
// received by the core are acknowledged and queued for the CPU.
// Optional build macro: UART_HOST_LOOPBACK_EN adds the 'loopback' input which,
// when 1, routes TX bytes straight into the RX queue without touching the core.
// Ports:
//   uart_clk, reset                   clock / asynchronous active-high reset
//   cpu_wdata, cpu_wr                 CPU byte push into TX queue
//   cpu_rd, cpu_rdata                 CPU pop of RX queue (fall-through head)
//   ovr_clr, rx_overrun               sticky lost-byte flag and its clear
//   tx_full, tx_idle, rx_empty        queue / sequencer status
//   uart_data_out, uart_write_data    byte and load strobe to the UART core
//   uart_buf_empty                    core transmit buffer empty
//   uart_data_in, uart_new_data       received byte and flag from the core
//   uart_read_data                    acknowledge that clears uart_new_data
//   loopback (UART_HOST_LOOPBACK_EN)  internal TX->RX loopback select
module uart_host
    import uart_pkg::*;
#(
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8
) (
    input  logic              uart_clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] cpu_wdata,
    input  logic              cpu_wr,
    input  logic              cpu_rd,
    input  logic              ovr_clr,
`ifdef UART_HOST_LOOPBACK_EN
    input  logic              loopback,
`endif
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              tx_full,
    output logic              tx_idle,
    output logic              rx_empty,
    output logic              rx_overrun,
    output logic [DATA_W-1:0] uart_data_out,
    output logic              uart_write_data,
    input  logic              uart_buf_empty,
    input  logic [DATA_W-1:0] uart_data_in,
    input  logic              uart_new_data,
    output logic              uart_read_data
);

    logic lb_mode;
`ifdef UART_HOST_LOOPBACK_EN
    assign lb_mode = loopback;
`else
    assign lb_mode = 1'b0;
`endif

    tx_state_t                   t_state, t_next;
    rx_state_t                   r_state, r_next;
    logic [DATA_W-1:0]           tx_head;
    logic [$clog2(TX_DEPTH):0]   tx_count;
    logic                        tx_full_w, tx_empty_w;
    logic [$clog2(RX_DEPTH):0]   rx_count;
    logic                        rx_full_w, rx_empty_w;
    logic                        tx_go, tx_push, lb_push, tx_lb_q;
    logic                        rx_take, rx_push, rx_pop_ok, rx_lost;
    logic [DATA_W-1:0]           rx_wdata;
    logic                        write_nxt, read_nxt, ovr_nxt;
    logic [DATA_W-1:0]           data_nxt;

    // Full is taken from the registered count, so a write is dropped even
    // when the sequencer pops in the same cycle.
    assign tx_push = cpu_wr && !tx_full_w;
    // In loopback the core is bypassed, so its buffer state does not gate.
    assign tx_go   = (t_state == T_IDLE) && !tx_empty_w && (lb_mode || uart_buf_empty);
    assign lb_push = tx_go && lb_mode;

    // While looping back, a pending core byte stays flagged until loopback
    // is released; the core holds it because it is never acknowledged.
    assign rx_take   = (r_state == R_IDLE) && uart_new_data && !lb_mode;
    assign rx_push   = rx_take || lb_push;
    assign rx_wdata  = lb_push ? tx_head : uart_data_in;
    assign rx_pop_ok = cpu_rd && (rx_count != '0);
    assign rx_lost   = rx_push && rx_full_w && !rx_pop_ok;

    assign tx_full  = tx_full_w;
    assign tx_idle  = (tx_count == '0) && (t_state == T_IDLE);
    assign rx_empty = rx_empty_w;

    uart_host_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .uart_clk (uart_clk),
        .reset    (reset),
        .push     (tx_push),
        .wdata    (cpu_wdata),
        .pop      (tx_go),
        .rdata    (tx_head),
        .count    (tx_count),
        .full     (tx_full_w),
        .empty    (tx_empty_w)
    );

    uart_host_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .uart_clk (uart_clk),
        .reset    (reset),
        .push     (rx_push),
        .wdata    (rx_wdata),
        .pop      (cpu_rd),
        .rdata    (cpu_rdata),
        .count    (rx_count),
        .full     (rx_full_w),
        .empty    (rx_empty_w)
    );

    // State and registered outputs
    always_ff @(posedge uart_clk or posedge reset) begin
        if (reset) begin
            t_state         <= T_IDLE;
            r_state         <= R_IDLE;
            tx_lb_q         <= 1'b0;
            uart_write_data <= 1'b0;
            uart_data_out   <= '0;
            uart_read_data  <= 1'b0;
            rx_overrun      <= 1'b0;
        end else begin
            t_state         <= t_next;
            r_state         <= r_next;
            tx_lb_q         <= lb_push;
            uart_write_data <= write_nxt;
            uart_data_out   <= data_nxt;
            uart_read_data  <= read_nxt;
            rx_overrun      <= ovr_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        t_next = t_state;
        case (t_state)
            T_IDLE:  if (tx_go) t_next = T_LOAD;
            // T_BUSY is a guard cycle while the core drops uart_buf_empty.
            T_LOAD:  t_next = tx_lb_q ? T_IDLE : T_BUSY;
            T_BUSY:  t_next = T_WAIT;
            T_WAIT:  if (uart_buf_empty) t_next = T_IDLE;
            default: t_next = T_IDLE;
        endcase

        r_next = r_state;
        case (r_state)
            R_IDLE:  if (rx_take) r_next = R_ACK;
            R_ACK:   r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    // Output decode: values registered on the edge that enters T_LOAD / R_ACK
    always_comb begin
        write_nxt = tx_go && !lb_mode;
        data_nxt  = write_nxt ? tx_head : uart_data_out;
        read_nxt  = rx_take;
        // A lost byte wins over a clear in the same cycle.
        if (rx_lost)      ovr_nxt = 1'b1;
        else if (ovr_clr) ovr_nxt = 1'b0;
        else              ovr_nxt = rx_overrun;
    end

endmodule

// File: tb/tb_uart_host.sv
module tb_uart_host;

    localparam int FRAME = 10;

    logic       uart_clk;
    logic       reset;
    logic [7:0] cpu_wdata;
    logic       cpu_wr, cpu_rd, ovr_clr;
`ifdef UART_HOST_LOOPBACK_EN
    logic       loopback;
`endif
    logic [7:0] cpu_rdata;
    logic       tx_full, tx_idle, rx_empty, rx_overrun;
    logic [7:0] uart_data_out;
    logic       uart_write_data, uart_buf_empty;
    logic [7:0] uart_data_in;
    logic       uart_new_data, uart_read_data;

    int         n_cmp, n_bad;
    int         cyc, busy_cnt, strobe_cnt, rdack_cnt;
    logic       core_hold;
    logic [7:0] strobe_data[$];
    int         strobe_cyc[$];

    uart_host #(.TX_DEPTH(8), .RX_DEPTH(8)) dut (
        .uart_clk        (uart_clk),
        .reset           (reset),
        .cpu_wdata       (cpu_wdata),
        .cpu_wr          (cpu_wr),
        .cpu_rd          (cpu_rd),
        .ovr_clr         (ovr_clr),
`ifdef UART_HOST_LOOPBACK_EN
        .loopback        (loopback),
`endif
        .cpu_rdata       (cpu_rdata),
        .tx_full         (tx_full),
        .tx_idle         (tx_idle),
        .rx_empty        (rx_empty),
        .rx_overrun      (rx_overrun),
        .uart_data_out   (uart_data_out),
        .uart_write_data (uart_write_data),
        .uart_buf_empty  (uart_buf_empty),
        .uart_data_in    (uart_data_in),
        .uart_new_data   (uart_new_data),
        .uart_read_data  (uart_read_data)
    );

    initial begin
        uart_clk = 1'b0;
        forever #5 uart_clk = ~uart_clk;
    end

    // UART core stand-in: busy for FRAME cycles after each load strobe,
    // records every strobe cycle and every acknowledge cycle.
    initial begin
        cyc = 0; busy_cnt = 0; strobe_cnt = 0; rdack_cnt = 0;
        uart_buf_empty = 1'b1;
        forever begin
            @(posedge uart_clk); #1;
            cyc++;
            if (reset) busy_cnt = 0;
            else if (uart_write_data) begin
                strobe_cnt++;
                strobe_data.push_back(uart_data_out);
                strobe_cyc.push_back(cyc);
                busy_cnt = FRAME;
            end else if (busy_cnt > 0) busy_cnt--;
            if (uart_read_data) rdack_cnt++;
            uart_buf_empty = !core_hold && (busy_cnt == 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge uart_clk); #2;
    endtask

    task automatic clear_log();
        strobe_cnt = 0;
        strobe_data.delete();
        strobe_cyc.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        n_cmp++; if (tx_idle !== 1'b1) begin n_bad++; $display("FAIL rst_tx_idle: got %b want 1", tx_idle); end
        n_cmp++; if (tx_full !== 1'b0) begin n_bad++; $display("FAIL rst_tx_full: got %b want 0", tx_full); end
        n_cmp++; if (rx_empty !== 1'b1) begin n_bad++; $display("FAIL rst_rx_empty: got %b want 1", rx_empty); end
        n_cmp++; if (rx_overrun !== 1'b0) begin n_bad++; $display("FAIL rst_overrun: got %b want 0", rx_overrun); end
        n_cmp++; if (cpu_rdata !== 8'h00) begin n_bad++; $display("FAIL rst_cpu_rdata: got %h want 00", cpu_rdata); end
        n_cmp++; if (uart_data_out !== 8'h00) begin n_bad++; $display("FAIL rst_data_out: got %h want 00", uart_data_out); end
        n_cmp++; if ({uart_write_data, uart_read_data} !== 2'b00) begin n_bad++; $display("FAIL rst_strobes: got %b want 00", {uart_write_data, uart_read_data}); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_tx();
        clear_log();
        cpu_wdata = 8'h55; cpu_wr = 1'b1; step(); cpu_wr = 1'b0;
        n_cmp++; if (tx_idle !== 1'b0) begin n_bad++; $display("FAIL tx1_busy: got tx_idle=%b want 0", tx_idle); end
        for (int i = 0; i < 100 && !(strobe_cnt >= 1 && tx_idle === 1'b1); i++) step();
        n_cmp++; if (strobe_cnt !== 1) begin n_bad++; $display("FAIL tx1_strobe_cycles: got %0d want 1", strobe_cnt); end
        n_cmp++; if (strobe_data.size() < 1 || strobe_data[0] !== 8'h55) begin n_bad++; $display("FAIL tx1_data: got %h want 55", (strobe_data.size() > 0) ? strobe_data[0] : 8'hxx); end
        n_cmp++; if (tx_idle !== 1'b1) begin n_bad++; $display("FAIL tx1_idle: got %b want 1", tx_idle); end
    endtask

    task automatic test_tx_fill();
        core_hold = 1'b1; step();
        clear_log();
        for (int i = 1; i <= 9; i++) begin
            cpu_wdata = 8'(i); cpu_wr = 1'b1; step();
        end
        cpu_wr = 1'b0;
        n_cmp++; if (tx_full !== 1'b1) begin n_bad++; $display("FAIL fill_full: got %b want 1", tx_full); end
        n_cmp++; if (strobe_cnt !== 0) begin n_bad++; $display("FAIL fill_held: got %0d strobes want 0", strobe_cnt); end
        core_hold = 1'b0;
        for (int i = 0; i < 400 && tx_idle !== 1'b1; i++) step();
        n_cmp++; if (strobe_cnt !== 8) begin n_bad++; $display("FAIL fill_count: got %0d want 8", strobe_cnt); end
        for (int i = 0; i < 8 && i < strobe_data.size(); i++) begin
            n_cmp++; if (strobe_data[i] !== 8'(i + 1)) begin n_bad++; $display("FAIL fill_data[%0d]: got %h want %h", i, strobe_data[i], 8'(i + 1)); end
        end
        for (int i = 1; i < strobe_cyc.size(); i++) begin
            n_cmp++; if (strobe_cyc[i] - strobe_cyc[i-1] !== FRAME + 2) begin n_bad++; $display("FAIL fill_gap[%0d]: got %0d want %0d", i, strobe_cyc[i] - strobe_cyc[i-1], FRAME + 2); end
        end
    endtask

    task automatic test_rx_single();
        rdack_cnt = 0;
        uart_data_in = 8'hA3; uart_new_data = 1'b1;
        step(); step();
        uart_new_data = 1'b0;
        step(); step();
        n_cmp++; if (rdack_cnt !== 1) begin n_bad++; $display("FAIL rx1_ack: got %0d acks want 1", rdack_cnt); end
        n_cmp++; if (rx_empty !== 1'b0) begin n_bad++; $display("FAIL rx1_empty: got %b want 0", rx_empty); end
        n_cmp++; if (cpu_rdata !== 8'hA3) begin n_bad++; $display("FAIL rx1_data: got %h want a3", cpu_rdata); end
        cpu_rd = 1'b1; step(); cpu_rd = 1'b0;
        n_cmp++; if (rx_empty !== 1'b1) begin n_bad++; $display("FAIL rx1_pop_empty: got %b want 1", rx_empty); end
        cpu_rd = 1'b1; step(); cpu_rd = 1'b0;
        n_cmp++; if (cpu_rdata !== 8'hA3) begin n_bad++; $display("FAIL rx1_hold: got %h want a3", cpu_rdata); end
        n_cmp++; if (rx_overrun !== 1'b0) begin n_bad++; $display("FAIL rx1_overrun: got %b want 0", rx_overrun); end
    endtask

    task automatic rx_event(input logic [7:0] b, input logic rd, input logic clr);
        uart_data_in = b; uart_new_data = 1'b1; cpu_rd = rd; ovr_clr = clr;
        step();
        uart_new_data = 1'b0; cpu_rd = 1'b0; ovr_clr = 1'b0;
        step();
    endtask

    task automatic test_rx_overrun();
        logic [7:0] exp_q[$];
        for (int i = 0; i < 9; i++) begin
            rx_event(8'h10 + 8'(i), 1'b0, 1'b0);
            if (i == 7) begin
                n_cmp++; if (rx_overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_at8: got %b want 0", rx_overrun); end
            end
        end
        n_cmp++; if (rx_overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set: got %b want 1", rx_overrun); end
        rx_event(8'h30, 1'b0, 1'b1);
        n_cmp++; if (rx_overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set_wins: got %b want 1", rx_overrun); end
        ovr_clr = 1'b1; step(); ovr_clr = 1'b0;
        n_cmp++; if (rx_overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_clr: got %b want 0", rx_overrun); end
        n_cmp++; if (cpu_rdata !== 8'h10) begin n_bad++; $display("FAIL ovr_head: got %h want 10", cpu_rdata); end
        rx_event(8'h20, 1'b1, 1'b0);
        n_cmp++; if (rx_overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_rd_push: got %b want 0", rx_overrun); end
        exp_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h20};
        foreach (exp_q[i]) begin
            n_cmp++; if (cpu_rdata !== exp_q[i]) begin n_bad++; $display("FAIL ovr_pop[%0d]: got %h want %h", i, cpu_rdata, exp_q[i]); end
            cpu_rd = 1'b1; step(); cpu_rd = 1'b0;
        end
        n_cmp++; if (rx_empty !== 1'b1) begin n_bad++; $display("FAIL ovr_drained: got %b want 1", rx_empty); end
    endtask

    task automatic test_reset_mid_frame();
        int snap;
        clear_log();
        for (int i = 0; i < 4; i++) begin
            cpu_wdata = 8'hA1 + 8'(i); cpu_wr = 1'b1; step();
        end
        cpu_wr = 1'b0;
        repeat (3) step();
        n_cmp++; if (strobe_cnt !== 1 || tx_idle !== 1'b0) begin n_bad++; $display("FAIL mid_pre: got strobes=%0d tx_idle=%b want 1 and 0", strobe_cnt, tx_idle); end
        #3 reset = 1'b1;
        step();
        n_cmp++; if (tx_idle !== 1'b1) begin n_bad++; $display("FAIL mid_idle: got %b want 1", tx_idle); end
        reset = 1'b0;
        snap = strobe_cnt;
        repeat (30) step();
        n_cmp++; if (strobe_cnt !== snap) begin n_bad++; $display("FAIL mid_no_strobe: got %0d strobes want %0d", strobe_cnt, snap); end
        n_cmp++; if (tx_idle !== 1'b1 || uart_data_out !== 8'h00) begin n_bad++; $display("FAIL mid_after: got tx_idle=%b data_out=%h want 1 00", tx_idle, uart_data_out); end
    endtask

`ifdef UART_HOST_LOOPBACK_EN
    task automatic test_loopback();
        int snap;
        snap = strobe_cnt;
        loopback = 1'b1;
        cpu_wdata = 8'h7E; cpu_wr = 1'b1; step(); cpu_wr = 1'b0;
        for (int i = 0; i < 20 && rx_empty !== 1'b0; i++) step();
        repeat (2) step();
        n_cmp++; if (cpu_rdata !== 8'h7E || rx_empty !== 1'b0) begin n_bad++; $display("FAIL lb_data: got %h empty=%b want 7e 0", cpu_rdata, rx_empty); end
        n_cmp++; if (strobe_cnt !== snap) begin n_bad++; $display("FAIL lb_no_strobe: got %0d want %0d", strobe_cnt, snap); end
        n_cmp++; if (tx_idle !== 1'b1) begin n_bad++; $display("FAIL lb_idle: got %b want 1", tx_idle); end
        cpu_rd = 1'b1; step(); cpu_rd = 1'b0;
        loopback = 1'b0;
    endtask
`endif

    initial begin
        n_cmp = 0; n_bad = 0;
        core_hold = 1'b0;
        reset = 1'b1;
        cpu_wdata = '0; cpu_wr = 1'b0; cpu_rd = 1'b0; ovr_clr = 1'b0;
        uart_data_in = '0; uart_new_data = 1'b0;
`ifdef UART_HOST_LOOPBACK_EN
        loopback = 1'b0;
`endif
        test_reset();
        test_single_tx();
        test_tx_fill();
        test_rx_single();
        test_rx_overrun();
        test_reset_mid_frame();
`ifdef UART_HOST_LOOPBACK_EN
        test_loopback();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
